// File: rtl/freq_sort.sv
// Sorts ten (symbol, count) pairs ascending by count with a 10-phase odd-even transposition network, then streams them out.
// Optional macro SORT_SKIP_ZERO_EN: zero-count entries are skipped during emission instead of presented.
module freq_sort (
  input  logic       Clk_in,
  input  logic       Rst,
  input  logic       Start,
  input  logic [8:0] Num0,
  input  logic [8:0] Num1,
  input  logic [8:0] Num2,
  input  logic [8:0] Num3,
  input  logic [8:0] Num4,
  input  logic [8:0] Num5,
  input  logic [8:0] Num6,
  input  logic [8:0] Num7,
  input  logic [8:0] Num8,
  input  logic [8:0] Num9,
  input  logic       Out_ready,
  output logic       Busy,
  output logic       Out_valid,
  output logic [3:0] Sym_out,
  output logic [8:0] Freq_out,
  output logic [3:0] Nz_count,
  output logic       Done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  logic [1:0] state_r, state_s;
  logic [3:0] phase_r, phase_s;
  logic [3:0] ptr_r, ptr_s;
  logic [3:0] sym_r  [10];
  logic [3:0] sym_s  [10];
  logic [8:0] freq_r [10];
  logic [8:0] freq_s [10];
  logic [8:0] num_s  [10];
  logic [3:0] nz_s;
  logic       cap_s;
  logic       adv_s;
  logic       valid_s;
  logic [3:0] sym_o_s;
  logic [8:0] freq_o_s;

  assign num_s[0] = Num0;
  assign num_s[1] = Num1;
  assign num_s[2] = Num2;
  assign num_s[3] = Num3;
  assign num_s[4] = Num4;
  assign num_s[5] = Num5;
  assign num_s[6] = Num6;
  assign num_s[7] = Num7;
  assign num_s[8] = Num8;
  assign num_s[9] = Num9;

  // Number of nonzero counts on the inputs, latched at capture
  always_comb begin
    nz_s = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (num_s[i] != 9'd0) begin
        nz_s = nz_s + 4'd1;
      end else begin
        nz_s = nz_s;
      end
    end
  end

  // Read pointer advance condition in EMIT
  always_comb begin
`ifdef SORT_SKIP_ZERO_EN
    adv_s = (Out_valid && Out_ready) || (freq_r[ptr_r] == 9'd0);
`else
    adv_s = Out_valid && Out_ready;
`endif
  end

  // Next-state, sort network and next output values
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    ptr_s   = ptr_r;
    sym_s   = sym_r;
    freq_s  = freq_r;
    cap_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          cap_s   = 1'b1;
          phase_s = 4'd0;
          ptr_s   = 4'd0;
          state_s = ST_SORT;
          for (int i = 0; i < 10; i++) begin
            sym_s[i]  = 4'(i);
            freq_s[i] = num_s[i];
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SORT: begin
        // Strict compare keeps equal counts in ascending symbol order
        for (int i = 0; i < 9; i++) begin
          if (((i & 1) == int'(phase_r[0])) && (freq_r[i] > freq_r[i+1])) begin
            sym_s[i]    = sym_r[i+1];
            sym_s[i+1]  = sym_r[i];
            freq_s[i]   = freq_r[i+1];
            freq_s[i+1] = freq_r[i];
          end else begin
            sym_s[i] = sym_s[i];
          end
        end
        if (phase_r == 4'd9) begin
          state_s = ST_EMIT;
          phase_s = 4'd0;
          ptr_s   = 4'd0;
        end else begin
          phase_s = phase_r + 4'd1;
        end
      end
      ST_EMIT: begin
        if (adv_s) begin
          if (ptr_r == 4'd9) begin
            state_s = ST_FIN;
          end else begin
            ptr_s = ptr_r + 4'd1;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
        ptr_s   = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (state_s == ST_EMIT) begin
`ifdef SORT_SKIP_ZERO_EN
      valid_s = (freq_s[ptr_s] != 9'd0);
`else
      valid_s = 1'b1;
`endif
      sym_o_s  = sym_s[ptr_s];
      freq_o_s = freq_s[ptr_s];
    end else begin
      valid_s  = 1'b0;
      sym_o_s  = 4'd0;
      freq_o_s = 9'd0;
    end
  end

  // State, array and registered outputs
  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      state_r   <= ST_IDLE;
      phase_r   <= 4'd0;
      ptr_r     <= 4'd0;
      for (int i = 0; i < 10; i++) begin
        sym_r[i]  <= 4'd0;
        freq_r[i] <= 9'd0;
      end
      Busy      <= 1'b0;
      Out_valid <= 1'b0;
      Sym_out   <= 4'd0;
      Freq_out  <= 9'd0;
      Nz_count  <= 4'd0;
      Done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      phase_r   <= phase_s;
      ptr_r     <= ptr_s;
      sym_r     <= sym_s;
      freq_r    <= freq_s;
      Busy      <= (state_s != ST_IDLE);
      Out_valid <= valid_s;
      Sym_out   <= sym_o_s;
      Freq_out  <= freq_o_s;
      Nz_count  <= cap_s ? nz_s : Nz_count;
      Done      <= (state_s == ST_FIN);
    end
  end

endmodule

// File: tb/tb_freq_sort.sv
// Directed self-checking bench for freq_sort: ordering, stability, stalls, reset and Start filtering.
// Expectations follow SORT_SKIP_ZERO_EN when the bench is compiled with it.
module tb_freq_sort;

  logic       Clk_in = 1'b0;
  logic       Rst;
  logic       Start;
  logic       Out_ready;
  logic [8:0] Num0, Num1, Num2, Num3, Num4, Num5, Num6, Num7, Num8, Num9;
  logic       Busy;
  logic       Out_valid;
  logic [3:0] Sym_out;
  logic [8:0] Freq_out;
  logic [3:0] Nz_count;
  logic       Done;

  logic [8:0] num_v    [10];
  logic [3:0] exp_sym  [10];
  logic [8:0] exp_freq [10];
  int checks   = 0;
  int failures = 0;

  assign Num0 = num_v[0];
  assign Num1 = num_v[1];
  assign Num2 = num_v[2];
  assign Num3 = num_v[3];
  assign Num4 = num_v[4];
  assign Num5 = num_v[5];
  assign Num6 = num_v[6];
  assign Num7 = num_v[7];
  assign Num8 = num_v[8];
  assign Num9 = num_v[9];

  freq_sort dut (
    .Clk_in    (Clk_in),
    .Rst       (Rst),
    .Start     (Start),
    .Num0      (Num0),
    .Num1      (Num1),
    .Num2      (Num2),
    .Num3      (Num3),
    .Num4      (Num4),
    .Num5      (Num5),
    .Num6      (Num6),
    .Num7      (Num7),
    .Num8      (Num8),
    .Num9      (Num9),
    .Out_ready (Out_ready),
    .Busy      (Busy),
    .Out_valid (Out_valid),
    .Sym_out   (Sym_out),
    .Freq_out  (Freq_out),
    .Nz_count  (Nz_count),
    .Done      (Done)
  );

  always #5 Clk_in = ~Clk_in;

  task automatic tick;
    @(posedge Clk_in);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_busy"}, 32'(Busy), 32'd0);
    check_val({tag, "_valid"}, 32'(Out_valid), 32'd0);
    check_val({tag, "_sym"}, 32'(Sym_out), 32'd0);
    check_val({tag, "_freq"}, 32'(Freq_out), 32'd0);
    check_val({tag, "_nz"}, 32'(Nz_count), 32'd0);
    check_val({tag, "_done"}, 32'(Done), 32'd0);
  endtask

  task automatic skip_zero_exp(inout int idx);
`ifdef SORT_SKIP_ZERO_EN
    while (idx < 10 && exp_freq[idx] == 9'd0) idx++;
`endif
  endtask

  // mode 0: ready always 1; mode 1: ready 1,0,0,1 over valid cycles; mode 2: Start pulsed in EMIT
  task automatic run_case(input string tag, input int mode, input int exp_first,
                          input int exp_done, input logic [3:0] exp_nz);
    int  cyc;
    int  idx;
    int  nvalid;
    int  first;
    bit  done_seen;
    Out_ready = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 10; i++) num_v[i] = 9'(i * 37 + 100);
    check_val({tag, "_busy_e0"}, 32'(Busy), 32'd1);
    check_val({tag, "_valid_e0"}, 32'(Out_valid), 32'd0);
    cyc = 0;
    idx = 0;
    nvalid = 0;
    first = -1;
    done_seen = 1'b0;
    while (!done_seen && cyc < 100) begin
      Out_ready = 1'b1;
      if (mode == 1) Out_ready = ((nvalid % 4) == 0) || ((nvalid % 4) == 3);
      Start = (mode == 2) && (cyc == 13 || cyc == 14);
      if (Out_valid) begin
        if (first < 0) first = cyc;
        skip_zero_exp(idx);
        if (idx < 10) begin
          check_val({tag, "_sym"}, 32'(Sym_out), 32'(exp_sym[idx]));
          check_val({tag, "_freq"}, 32'(Freq_out), 32'(exp_freq[idx]));
        end else begin
          check_val({tag, "_extra_entry"}, 32'(idx), 32'd9);
        end
        nvalid++;
        if (Out_ready) idx++;
      end
      if (Done) begin
        done_seen = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    Start = 1'b0;
    check_val({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    if (done_seen) begin
      skip_zero_exp(idx);
      check_val({tag, "_entries"}, 32'(idx), 32'd10);
      check_val({tag, "_first_valid"}, 32'(first), 32'(exp_first));
      check_val({tag, "_done_cycle"}, 32'(cyc), 32'(exp_done));
      check_val({tag, "_nz"}, 32'(Nz_count), 32'(exp_nz));
      check_val({tag, "_busy_fin"}, 32'(Busy), 32'd1);
      tick();
      check_val({tag, "_done_pulse"}, 32'(Done), 32'd0);
      check_val({tag, "_busy_idle"}, 32'(Busy), 32'd0);
    end
  endtask

  initial begin
    Rst = 1'b1;
    Start = 1'b0;
    Out_ready = 1'b1;
    for (int i = 0; i < 10; i++) num_v[i] = 9'd0;
    tick();
    tick();
    check_zero("reset");
    Rst = 1'b0;
    tick();

    // Reverse counts: symbol 9 (count 0) first, symbol 0 (count 9) last
    num_v    = '{9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0};
    exp_sym  = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    exp_freq = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8, 9'd9};
`ifdef SORT_SKIP_ZERO_EN
    run_case("reverse", 0, 11, 20, 4'd9);
`else
    run_case("reverse", 0, 10, 20, 4'd9);
`endif

    // All equal: stable order
    num_v    = '{9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5};
    exp_sym  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    exp_freq = '{9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5, 9'd5};
    run_case("equal", 0, 10, 20, 4'd10);

    // Sparse counts with zeros
    num_v    = '{9'd0, 9'd0, 9'd3, 9'd0, 9'd1, 9'd0, 9'd0, 9'd0, 9'd0, 9'd2};
    exp_sym  = '{4'd0, 4'd1, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd4, 4'd9, 4'd2};
    exp_freq = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd1, 9'd2, 9'd3};
`ifdef SORT_SKIP_ZERO_EN
    run_case("sparse", 0, 17, 20, 4'd3);
`else
    run_case("sparse", 0, 10, 20, 4'd3);
`endif

    // Mixed counts with ties, downstream stalls 1,0,0,1
    num_v    = '{9'd3, 9'd1, 9'd4, 9'd1, 9'd5, 9'd9, 9'd2, 9'd6, 9'd5, 9'd3};
    exp_sym  = '{4'd1, 4'd3, 4'd6, 4'd0, 4'd9, 4'd2, 4'd4, 4'd8, 4'd7, 4'd5};
    exp_freq = '{9'd1, 9'd1, 9'd2, 9'd3, 9'd3, 9'd4, 9'd5, 9'd5, 9'd6, 9'd9};
    run_case("stall", 1, 10, 30, 4'd10);

    // Same counts, Start re-asserted during EMIT
    num_v = '{9'd3, 9'd1, 9'd4, 9'd1, 9'd5, 9'd9, 9'd2, 9'd6, 9'd5, 9'd3};
    run_case("restart", 2, 10, 20, 4'd10);

    // Reset at SORT phase 4, with Start also high at the reset edge
    num_v = '{9'd9, 9'd8, 9'd7, 9'd6, 9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0};
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_val("midsort_busy", 32'(Busy), 32'd1);
    Rst = 1'b1;
    Start = 1'b1;
    tick();
    Rst = 1'b0;
    Start = 1'b0;
    check_zero("midsort_rst");
    tick();
    check_val("midsort_idle", 32'(Busy), 32'd0);

    // Fresh counts after reset, 511 must come out last
    num_v    = '{9'd10, 9'd511, 9'd0, 9'd20, 9'd7, 9'd7, 9'd300, 9'd1, 9'd2, 9'd3};
    exp_sym  = '{4'd2, 4'd7, 4'd8, 4'd9, 4'd4, 4'd5, 4'd0, 4'd3, 4'd6, 4'd1};
    exp_freq = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd7, 9'd7, 9'd10, 9'd20, 9'd300, 9'd511};
`ifdef SORT_SKIP_ZERO_EN
    run_case("max", 0, 11, 20, 4'd9);
`else
    run_case("max", 0, 10, 20, 4'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
